countdown_timer: RTL and testbench

Programmable modulo down-counter/timer. It is the counting-down counterpart of the team's mod-12 up-counter with an overflow flag. It loads a start value, decrements once per clock while running, and flags underflow at zero. It then either reloads (periodic tick) or halts (one-shot). Typical use is as a tick/timeout generator for lab sequencing logic.

---
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: programmable modulo down-counter with periodic (auto-reload)
// and one-shot modes. Counts from a clamped start value down to zero, flags
// underflow while sitting at zero in RUN, then reloads or parks in DONE.
module countdown_timer #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             underflow,
    output logic             busy,
    output logic             done
);

    // Largest legal count; also the reset value of counter and reload register.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    // Saturate out-of-range load values so the counter never leaves 0..MODULUS-1.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} > {1'b0, MAX_VAL}) begin
            r = MAX_VAL;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // State, counter and reload registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= MAX_VAL;
            reload_q <= MAX_VAL;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    // Next-state logic; priority is load > stop > start.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        if (load) begin
            // Load always returns to IDLE, aborting a run or clearing DONE.
            count_d  = clamp(load_value);
            reload_d = clamp(load_value);
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Counting resumes from the held value; stop outranks start.
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Stop even at zero: no reload and no DONE transition.
                        state_d = ST_IDLE;
                    end else if (count_q == {WIDTH{1'b0}}) begin
                        // Zero is never decremented: reload or finish instead.
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // Restart of the one-shot from the reload register.
                    if (start) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = MAX_VAL;
                end
            endcase
        end
    end

    // Outputs decode directly from registers; counter already holds 0 in DONE.
    assign out       = count_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign underflow = (state_q == ST_RUN) && (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=4, MODULUS=12).
module tb_countdown_timer;

    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] out;
    logic       underflow;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int pulses;

    countdown_timer #(.WIDTH(4), .MODULUS(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .out         (out),
        .underflow   (underflow),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_out, input logic e_uf,
                           input logic e_busy, input logic e_done);
        chk({tag, ".out"},  32'(out),       32'(e_out));
        chk({tag, ".uf"},   32'(underflow), 32'(e_uf));
        chk({tag, ".busy"}, 32'(busy),      32'(e_busy));
        chk({tag, ".done"}, 32'(done),      32'(e_done));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_value = 4'd0; start = 1'b0;
        stop = 1'b0; auto_reload = 1'b0;
        #12;
        chk_all("reset", 4'd11, 1'b0, 1'b0, 1'b0);
        #5 reset = 1'b0;

        // One-shot: load 5, run 5..0, then DONE.
        load = 1'b1; load_value = 4'd5; tick();
        load = 1'b0;
        chk_all("os_load", 4'd5, 1'b0, 1'b0, 1'b0);
        start = 1'b1; auto_reload = 1'b0; tick();
        start = 1'b0;
        chk_all("os_run5", 4'd5, 1'b0, 1'b1, 1'b0);
        for (int k = 4; k >= 0; k--) begin
            tick();
            chk_all($sformatf("os_run%0d", k), 4'(k), (k == 0), 1'b1, 1'b0);
        end
        tick();
        chk_all("os_done", 4'd0, 1'b0, 1'b0, 1'b1);
        stop = 1'b1; tick(); stop = 1'b0;
        chk_all("os_done_stop", 4'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk_all("os_restart", 4'd5, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("os_restart4", 4'd4, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-count, checked between clock edges.
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 4'd11, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Periodic: reload 2, sequence 2,1,0 repeating; count underflow pulses.
        load = 1'b1; load_value = 4'd2; tick(); load = 1'b0;
        chk_all("per_load", 4'd2, 1'b0, 1'b0, 1'b0);
        auto_reload = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk_all("per_j0", 4'd2, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (underflow === 1'b1) pulses++;
            chk_all($sformatf("per_j%0d", j), 4'(2 - (j % 3)), (j % 3 == 2), 1'b1, 1'b0);
        end
        chk("per_pulses", 32'(pulses), 32'd4);

        // Reload 0: underflow stays high while running.
        load = 1'b1; load_value = 4'd0; tick(); load = 1'b0;
        chk_all("zero_load", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk_all("zero_run0", 4'd0, 1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk_all($sformatf("zero_run%0d", j), 4'd0, 1'b1, 1'b1, 1'b0);
        end

        // Stop at 7, resume at 6, start+stop together.
        load = 1'b1; load_value = 4'd9; tick(); load = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk_all("ctl_run9", 4'd9, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk_all("ctl_run7", 4'd7, 1'b0, 1'b1, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk_all("ctl_stop7", 4'd7, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("ctl_hold7", 4'd7, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk_all("ctl_resume", 4'd7, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ctl_run6", 4'd6, 1'b0, 1'b1, 1'b0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk_all("ctl_both", 4'd6, 1'b0, 1'b0, 1'b0);

        // Clamp and priority.
        load = 1'b1; load_value = 4'd15; tick(); load = 1'b0;
        chk_all("clamp15", 4'd11, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_value = 4'd12; tick(); load = 1'b0;
        chk_all("clamp12", 4'd11, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_value = 4'd3; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
        chk_all("ld_start", 4'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk_all("ld_run2", 4'd2, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_value = 4'd8; tick(); load = 1'b0;
        chk_all("ld_abort", 4'd8, 1'b0, 1'b0, 1'b0);

        // Stop at zero in periodic mode: no reload, no DONE.
        load = 1'b1; load_value = 4'd1; tick(); load = 1'b0;
        auto_reload = 1'b1; start = 1'b1; tick(); start = 1'b0;
        tick();
        chk_all("sz_run0", 4'd0, 1'b1, 1'b1, 1'b0);
        stop = 1'b1; tick(); stop = 1'b0;
        chk_all("sz_stop", 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("sz_hold", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
